// File: rtl/axis_iq_deinterleaver_if.sv
// AXI-Stream bundle used for the interleaved input and for the real/imag outputs.
// master drives payload and valid; slave drives ready.
interface axis_iq_deinterleaver_if #(
    parameter int DATA_WIDTH = 128
) ();
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    modport master (output tdata, tkeep, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_iq_deinterleaver.sv
// Splits an interleaved I/Q stream into lockstep real and imag AXI-Stream channels.
// Two input beats (LO then HI half) form one output beat per channel.
module axis_iq_deinterleaver #(
    parameter int DATA_WIDTH   = 128,
    parameter int SAMPLE_WIDTH = 16,
    parameter int SAMPLES      = DATA_WIDTH / SAMPLE_WIDTH,
    parameter int PAIRS        = SAMPLES / 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                   clock,
    input  logic                   resetn,
    axis_iq_deinterleaver_if.slave  s_axis_mm2s,
    axis_iq_deinterleaver_if.master m_axis_real,
    axis_iq_deinterleaver_if.master m_axis_imag,
    output logic                   frame_err,
    output logic [CNT_WIDTH-1:0]   frame_count
);
    localparam int BYTES_PER_SAMPLE = SAMPLE_WIDTH / 8;
    localparam int HALF_WIDTH       = PAIRS * SAMPLE_WIDTH;

    typedef enum logic {
        PH_LO = 1'b0,
        PH_HI = 1'b1
    } phase_t;

    phase_t phase_q, phase_d;

    logic [SAMPLES-1:0][SAMPLE_WIDTH-1:0] lane;
    logic [HALF_WIDTH-1:0] in_re, in_im;
    logic [HALF_WIDTH-1:0] hold_re, hold_im;
    logic [DATA_WIDTH-1:0] load_re, load_im;
    logic [DATA_WIDTH-1:0] real_data, imag_data;
    logic real_pend, imag_pend, real_last, imag_last;
    logic real_hs, imag_hs, out_free, in_fire;
    logic capture_lo, load_out, load_last, set_err;

    // A lane survives only when every byte of it is kept.
    always_comb begin
        for (int k = 0; k < SAMPLES; k++) begin
            lane[k] = (&s_axis_mm2s.tkeep[k*BYTES_PER_SAMPLE +: BYTES_PER_SAMPLE])
                    ? s_axis_mm2s.tdata[k*SAMPLE_WIDTH +: SAMPLE_WIDTH]
                    : '0;
        end
    end

    always_comb begin
        for (int p = 0; p < PAIRS; p++) begin
            in_re[p*SAMPLE_WIDTH +: SAMPLE_WIDTH] = lane[2*p];
            in_im[p*SAMPLE_WIDTH +: SAMPLE_WIDTH] = lane[2*p+1];
        end
    end

    assign real_hs  = real_pend & m_axis_real.tready;
    assign imag_hs  = imag_pend & m_axis_imag.tready;
    assign out_free = (~real_pend | m_axis_real.tready) & (~imag_pend | m_axis_imag.tready);
    assign s_axis_mm2s.tready = resetn & out_free;
    assign in_fire  = s_axis_mm2s.tvalid & s_axis_mm2s.tready;

    always_ff @(posedge clock) begin
        if (!resetn) phase_q <= PH_LO;
        else         phase_q <= phase_d;
    end

    always_comb begin
        phase_d = phase_q;
        if (in_fire) begin
            case (phase_q)
                PH_LO: if (!s_axis_mm2s.tlast) phase_d = PH_HI;
                PH_HI: phase_d = PH_LO;
            endcase
        end
    end

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        capture_lo = 1'b0;
        load_out   = 1'b0;
        load_last  = 1'b0;
        set_err    = 1'b0;
        load_re    = {{HALF_WIDTH{1'b0}}, in_re};
        load_im    = {{HALF_WIDTH{1'b0}}, in_im};
        case (phase_q)
            PH_LO: begin
                if (in_fire) begin
                    if (s_axis_mm2s.tlast) begin
                        load_out  = 1'b1;
                        load_last = 1'b1;
                        set_err   = 1'b1;
                    end else begin
                        capture_lo = 1'b1;
                    end
                end
            end
            PH_HI: begin
                load_re   = {in_re, hold_re};
                load_im   = {in_im, hold_im};
                load_out  = in_fire;
                load_last = s_axis_mm2s.tlast;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            // NOTE: the LO holding registers are cleared too, so no pre-reset half can leak into a later beat.
            hold_re     <= '0;
            hold_im     <= '0;
            real_data   <= '0;
            imag_data   <= '0;
            real_last   <= 1'b0;
            imag_last   <= 1'b0;
            real_pend   <= 1'b0;
            imag_pend   <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= '0;
        end else begin
            if (capture_lo) begin
                hold_re <= in_re;
                hold_im <= in_im;
            end
            // A load only happens when both channels are free, so it may overwrite the flags.
            if (load_out) begin
                real_data <= load_re;
                imag_data <= load_im;
                real_last <= load_last;
                imag_last <= load_last;
                real_pend <= 1'b1;
                imag_pend <= 1'b1;
            end else begin
                if (real_hs) real_pend <= 1'b0;
                if (imag_hs) imag_pend <= 1'b0;
            end
            if (set_err) frame_err <= 1'b1;
            if (load_out && load_last) frame_count <= frame_count + CNT_WIDTH'(1);
        end
    end

    assign m_axis_real.tdata  = real_data;
    assign m_axis_real.tkeep  = '1;
    assign m_axis_real.tvalid = real_pend;
    assign m_axis_real.tlast  = real_last;
    assign m_axis_imag.tdata  = imag_data;
    assign m_axis_imag.tkeep  = '1;
    assign m_axis_imag.tvalid = imag_pend;
    assign m_axis_imag.tlast  = imag_last;
endmodule

// File: tb/tb_axis_iq_deinterleaver.sv
// Directed bench for axis_iq_deinterleaver: framing, backpressure, odd frames, tkeep, reset.
module tb_axis_iq_deinterleaver;
    logic        clock;
    logic        resetn;
    logic        frame_err;
    logic [15:0] frame_count;
    int          checks = 0;
    int          failures = 0;
    int          stall_cycles = 0;
    int          exp_fc = 0;

    axis_iq_deinterleaver_if #(.DATA_WIDTH(128)) s_if ();
    axis_iq_deinterleaver_if #(.DATA_WIDTH(128)) re_if ();
    axis_iq_deinterleaver_if #(.DATA_WIDTH(128)) im_if ();

    axis_iq_deinterleaver dut (
        .clock       (clock),
        .resetn      (resetn),
        .s_axis_mm2s (s_if),
        .m_axis_real (re_if),
        .m_axis_imag (im_if),
        .frame_err   (frame_err),
        .frame_count (frame_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Input beat: pair p carries I = base+p, Q = -(base+p).
    function automatic logic [127:0] mk_beat(input int base);
        logic [127:0] r;
        logic [15:0]  v;
        for (int p = 0; p < 4; p++) begin
            v = 16'(base + p);
            r[(2*p)*16 +: 16]   = v;
            r[(2*p+1)*16 +: 16] = -v;
        end
        return r;
    endfunction

    // Expected output: samples 0..3 from lo_base, 4..7 from hi_base; zmask forces samples to 0.
    function automatic logic [127:0] exp_ch(input int lo_base, input int hi_base,
                                            input bit is_imag, input logic [7:0] zmask);
        logic [127:0] r;
        logic [15:0]  v;
        for (int j = 0; j < 8; j++) begin
            v = (j < 4) ? 16'(lo_base + j) : 16'(hi_base + j - 4);
            if (is_imag) v = -v;
            if (zmask[j]) v = '0;
            r[j*16 +: 16] = v;
        end
        return r;
    endfunction

    task automatic push(input logic [127:0] d, input logic [15:0] k, input logic l);
        int w = 0;
        s_if.tdata  = d;
        s_if.tkeep  = k;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        @(negedge clock);
        while (!s_if.tready && w < 50) begin
            w++;
            @(negedge clock);
        end
        stall_cycles += w;
        check("push_accepted", 128'(w < 50), 128'(1));
        @(posedge clock);
        #1;
        s_if.tvalid = 1'b0;
    endtask

    initial begin
        resetn       = 1'b0;
        s_if.tvalid  = 1'b0;
        s_if.tdata   = '0;
        s_if.tkeep   = '1;
        s_if.tlast   = 1'b0;
        re_if.tready = 1'b1;
        im_if.tready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_tready", 128'(s_if.tready), 128'(0));
        check("rst_real_tvalid", 128'(re_if.tvalid), 128'(0));
        check("rst_imag_tvalid", 128'(im_if.tvalid), 128'(0));
        check("rst_real_tdata", re_if.tdata, 128'(0));
        check("rst_frame_err", 128'(frame_err), 128'(0));
        check("rst_frame_count", 128'(frame_count), 128'(0));
        @(posedge clock);
        #1;
        resetn = 1'b1;

        // Two-beat frame, both readies high.
        push(128'hFFFC_0004_FFFD_0003_FFFE_0002_FFFF_0001, 16'hFFFF, 1'b0);
        check("t1_no_early_valid", 128'(re_if.tvalid), 128'(0));
        push(128'hFFF8_0008_FFF9_0007_FFFA_0006_FFFB_0005, 16'hFFFF, 1'b1);
        exp_fc++;
        check("t1_real_tvalid", 128'(re_if.tvalid), 128'(1));
        check("t1_imag_tvalid", 128'(im_if.tvalid), 128'(1));
        check("t1_real_tdata", re_if.tdata, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        check("t1_imag_tdata", im_if.tdata, 128'hFFF8_FFF9_FFFA_FFFB_FFFC_FFFD_FFFE_FFFF);
        check("t1_real_tlast", 128'(re_if.tlast), 128'(1));
        check("t1_imag_tlast", 128'(im_if.tlast), 128'(1));
        check("t1_frame_count", 128'(frame_count), 128'(exp_fc));
        @(posedge clock);
        #1;
        check("t1_real_drained", 128'(re_if.tvalid), 128'(0));

        // Imag channel stalled while real is taken.
        im_if.tready = 1'b0;
        push(mk_beat(9), 16'hFFFF, 1'b0);
        push(mk_beat(13), 16'hFFFF, 1'b1);
        exp_fc++;
        check("t2_tready_blocked", 128'(s_if.tready), 128'(0));
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            #1;
            check("t2_real_tvalid_low", 128'(re_if.tvalid), 128'(0));
            check("t2_imag_tvalid_held", 128'(im_if.tvalid), 128'(1));
            check("t2_imag_tdata_held", im_if.tdata, exp_ch(9, 13, 1'b1, 8'h00));
            check("t2_tready_low", 128'(s_if.tready), 128'(0));
        end
        im_if.tready = 1'b1;
        #1;
        check("t2_tready_same_cycle", 128'(s_if.tready), 128'(1));
        @(posedge clock);
        #1;
        check("t2_imag_drained", 128'(im_if.tvalid), 128'(0));
        check("t2_real_tdata", re_if.tdata, exp_ch(9, 13, 1'b0, 8'h00));

        // Three-beat frame: the last beat lands in LO.
        push(mk_beat(17), 16'hFFFF, 1'b0);
        push(mk_beat(21), 16'hFFFF, 1'b0);
        check("t3_first_tlast", 128'(re_if.tlast), 128'(0));
        check("t3_first_real", re_if.tdata, exp_ch(17, 21, 1'b0, 8'h00));
        check("t3_err_clear", 128'(frame_err), 128'(0));
        push(mk_beat(25), 16'hFFFF, 1'b1);
        exp_fc++;
        check("t3_odd_real", re_if.tdata, exp_ch(25, 0, 1'b0, 8'hF0));
        check("t3_odd_imag", im_if.tdata, exp_ch(25, 0, 1'b1, 8'hF0));
        check("t3_odd_real_tlast", 128'(re_if.tlast), 128'(1));
        check("t3_odd_imag_tlast", 128'(im_if.tlast), 128'(1));
        check("t3_frame_err", 128'(frame_err), 128'(1));
        check("t3_frame_count", 128'(frame_count), 128'(exp_fc));
        push(mk_beat(29), 16'hFFFF, 1'b0);
        push(mk_beat(33), 16'hFFFF, 1'b1);
        exp_fc++;
        check("t3_sticky_err", 128'(frame_err), 128'(1));
        check("t3_after_odd_real", re_if.tdata, exp_ch(29, 33, 1'b0, 8'h00));

        // Reset with a LO half captured.
        push(mk_beat(37), 16'hFFFF, 1'b0);
        resetn = 1'b0;
        #1;
        check("t5_tready_gated", 128'(s_if.tready), 128'(0));
        @(posedge clock);
        #1;
        check("t5_real_tdata_zero", re_if.tdata, 128'(0));
        check("t5_imag_tdata_zero", im_if.tdata, 128'(0));
        check("t5_real_tlast_zero", 128'(re_if.tlast), 128'(0));
        check("t5_real_tvalid_zero", 128'(re_if.tvalid), 128'(0));
        check("t5_frame_err_zero", 128'(frame_err), 128'(0));
        check("t5_frame_count_zero", 128'(frame_count), 128'(0));
        resetn = 1'b1;
        exp_fc = 0;
        push(mk_beat(41), 16'hFFFF, 1'b0);
        check("t5_no_output_on_lo", 128'(re_if.tvalid), 128'(0));
        push(mk_beat(45), 16'hFFFF, 1'b1);
        exp_fc++;
        check("t5_real_tdata", re_if.tdata, exp_ch(41, 45, 1'b0, 8'h00));
        check("t5_imag_tdata", im_if.tdata, exp_ch(41, 45, 1'b1, 8'h00));
        check("t5_frame_count", 128'(frame_count), 128'(exp_fc));

        // tkeep masking: byte 14 dropped on LO (imag sample 3), lanes 0..1 dropped on HI (sample 4).
        push(mk_beat(49), 16'hBFFF, 1'b0);
        push(mk_beat(53), 16'hFFF0, 1'b1);
        exp_fc++;
        check("t4_real_tdata", re_if.tdata, exp_ch(49, 53, 1'b0, 8'h10));
        check("t4_imag_tdata", im_if.tdata, exp_ch(49, 53, 1'b1, 8'h18));
        check("t4_frame_err", 128'(frame_err), 128'(0));

        // Sixteen back-to-back beats, tlast every fourth.
        stall_cycles = 0;
        for (int i = 0; i < 16; i++) begin
            push(mk_beat(100 + 4*i), 16'hFFFF, 1'(i % 4 == 3));
            if (i % 2 == 1) begin
                if (i % 4 == 3) exp_fc++;
                check("t6_real_tvalid", 128'(re_if.tvalid), 128'(1));
                check("t6_real_tlast", 128'(re_if.tlast), 128'(i % 4 == 3));
                check("t6_imag_tlast", 128'(im_if.tlast), 128'(i % 4 == 3));
                check("t6_real_tdata", re_if.tdata, exp_ch(100 + 4*(i-1), 100 + 4*i, 1'b0, 8'h00));
                check("t6_imag_tdata", im_if.tdata, exp_ch(100 + 4*(i-1), 100 + 4*i, 1'b1, 8'h00));
            end else begin
                check("t6_lo_no_valid", 128'(re_if.tvalid), 128'(0));
            end
        end
        check("t6_no_stall", 128'(stall_cycles), 128'(0));
        check("t6_frame_count", 128'(frame_count), 128'(exp_fc));
        check("t6_frame_err", 128'(frame_err), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
